// File: rtl/key_pkg.sv
// Shared timing defaults, key index names and width helper for the key debounce bank.
package key_pkg;

    localparam int DEBOUNCE_CYCLES_50M = 1000000;
    localparam int REPEAT_DELAY_50M    = 25000000;
    localparam int REPEAT_PERIOD_50M   = 5000000;

    localparam int KEY_CONFIRM = 0;
    localparam int KEY_BACK    = 1;
    localparam int KEY_NEXT    = 2;
    localparam int KEY_PREV    = 3;
    localparam int KEY_RESET   = 4;

    // Bits needed to hold values 0 .. value-1; never less than 1.
    function automatic int key_clog2(input int value);
        int w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_1ch.sv
// Purpose: one-key synchroniser + debouncer producing level, press and release pulses.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES from raw edge to level/pulse.
// Backpressure: none; free-running level path. Auto-repeat built only with KEY_REPEAT_EN.
module key_debounce_1ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_HIGH     = 1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_50M,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_err
        $error("key_debounce_1ch: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Inverting ahead of the first flop lets a reset value of 0 mean "released" for either polarity.
    logic raw_norm;
    assign raw_norm = (ACTIVE_HIGH != 0) ? key_raw : ~key_raw;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef KEY_REPEAT_EN
    localparam int HOLD_W = key_clog2(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    always_comb begin
        sync1_d   = raw_norm;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            level_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

`ifdef KEY_REPEAT_EN
        // Reload to DELAY-PERIOD so later repeats land every REPEAT_PERIOD cycles.
        hold_d = hold_q;
        if (!level_q || !level_d) begin
            hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
            hold_d  = HOLD_RELOAD;
            press_d = 1'b1;
        end else begin
            hold_d = hold_q + HOLD_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Purpose: bank of NUM_KEYS independent debouncers plus any_press summary (KEY_REPEAT_EN adds auto-repeat).
// Latency: 2 sync cycles + DEBOUNCE_CYCLES per key; any_press is combinational from the pulse flops.
// Backpressure: none; outputs are levels and single-cycle pulses.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_HIGH     = 1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_50M,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50M
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_press
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_1ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_HIGH     (ACTIVE_HIGH),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

    assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboarded bench for key_debounce_bank with short debounce/repeat timings.
module tb_key_debounce_bank;
    import key_pkg::*;

    localparam int NK  = 5;
    localparam int LAT = 18;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          any_press;

    key_debounce_bank #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (16),
        .CNT_W           (5),
        .ACTIVE_HIGH     (1),
        .REPEAT_DELAY    (64),
        .REPEAT_PERIOD   (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .any_press   (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int key;
        bit is_press;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  press_cyc[NK];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int key, input bit is_press, input int at);
        ev_t e;
        e.key = key;
        e.is_press = is_press;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: each pulse must match a pending scoreboard entry within +-1 cycle.
    always @(negedge clk) begin
        bit seen;
        bit exp_any;
        seen    = 1'b0;
        exp_any = 1'b0;
        for (int k = 0; k < NK; k++) begin
            if (key_press[k] === 1'b1 && key_release[k] === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL both_pulses key %0d: press and release together at cycle %0d", k, cyc);
            end
            for (int p = 0; p < 2; p++) begin
                logic pulse;
                pulse = (p == 1) ? key_press[k] : key_release[k];
                if (pulse === 1'b1) begin
                    int idx;
                    idx  = -1;
                    seen = 1'b1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (idx < 0 && sb[j].key == k && sb[j].is_press == (p == 1) &&
                            cyc >= sb[j].cyc - 1 && cyc <= sb[j].cyc + 1) begin
                            idx = j;
                        end
                    end
                    n_tests++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL unexpected_%s key %0d: pulse at cycle %0d, none expected",
                                 (p == 1) ? "press" : "release", k, cyc);
                    end else begin
                        if (p == 1) begin
                            exp_any = 1'b1;
                            press_cyc[k] = cyc;
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
        if (seen || any_press !== 1'b0) begin
            check("any_press", 32'(any_press), 32'(exp_any));
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (cyc > sb[j].cyc + 1) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_%s key %0d: no pulse by cycle %0d, expected at %0d",
                         sb[j].is_press ? "press" : "release", sb[j].key, cyc, sb[j].cyc);
                sb.delete(j);
            end
        end
    end

    initial begin
        int t_acc;
        for (int k = 0; k < NK; k++) press_cyc[k] = -1;
        rst_n   = 1'b0;
        key_raw = '0;
        wait_cyc(3);
        check("reset_level", 32'(key_level), 32'h0);
        check("reset_press", 32'(key_press), 32'h0);
        check("reset_release", 32'(key_release), 32'h0);
        rst_n = 1'b1;
        wait_cyc(7);

        // Clean press and release on key 0.
        key_raw[KEY_CONFIRM] = 1'b1;
        expect_ev(KEY_CONFIRM, 1'b1, cyc + LAT);
        wait_cyc(25);
        check("k0_level_high", 32'(key_level), 32'h01);
        key_raw[KEY_CONFIRM] = 1'b0;
        expect_ev(KEY_CONFIRM, 1'b0, cyc + LAT);
        wait_cyc(25);
        check("k0_level_low", 32'(key_level), 32'h00);

        // Bouncing key 1: no mismatch run reaches 16 cycles.
        key_raw[KEY_BACK] = 1'b1; wait_cyc(5);
        key_raw[KEY_BACK] = 1'b0; wait_cyc(3);
        key_raw[KEY_BACK] = 1'b1; wait_cyc(5);
        key_raw[KEY_BACK] = 1'b0; wait_cyc(3);
        wait_cyc(30);
        check("k1_bounce_level", 32'(key_level), 32'h00);

        // Key 2 held then released.
        key_raw[KEY_NEXT] = 1'b1;
        expect_ev(KEY_NEXT, 1'b1, cyc + LAT);
        wait_cyc(25);
        check("k2_level_high", 32'(key_level), 32'h04);
        key_raw[KEY_NEXT] = 1'b0;
        expect_ev(KEY_NEXT, 1'b0, cyc + LAT);
        wait_cyc(25);
        check("k2_level_low", 32'(key_level), 32'h00);

        // Keys 3 and 4 together.
        key_raw[KEY_PREV]  = 1'b1;
        key_raw[KEY_RESET] = 1'b1;
        expect_ev(KEY_PREV, 1'b1, cyc + LAT);
        expect_ev(KEY_RESET, 1'b1, cyc + LAT);
        wait_cyc(25);
        check("k34_level_high", 32'(key_level), 32'h18);
        n_tests++;
        if (press_cyc[KEY_PREV] < 0 || press_cyc[KEY_PREV] != press_cyc[KEY_RESET]) begin
            n_fail++;
            $display("FAIL k34_same_cycle: key3 pressed at %0d, key4 at %0d, required equal",
                     press_cyc[KEY_PREV], press_cyc[KEY_RESET]);
        end
        key_raw[KEY_PREV]  = 1'b0;
        key_raw[KEY_RESET] = 1'b0;
        expect_ev(KEY_PREV, 1'b0, cyc + LAT);
        expect_ev(KEY_RESET, 1'b0, cyc + LAT);
        wait_cyc(25);
        check("k34_level_low", 32'(key_level), 32'h00);

        // Key 0 held, reset mid-count, then held through reset release.
        key_raw[KEY_CONFIRM] = 1'b1;
        wait_cyc(10);
        rst_n = 1'b0;
        wait_cyc(1);
        check("midrst_level", 32'(key_level), 32'h0);
        check("midrst_press", 32'(key_press), 32'h0);
        check("midrst_release", 32'(key_release), 32'h0);
        check("midrst_any", 32'(any_press), 32'h0);
        wait_cyc(3);
        rst_n = 1'b1;
        t_acc = cyc + LAT;
        expect_ev(KEY_CONFIRM, 1'b1, t_acc);
`ifdef KEY_REPEAT_EN
        expect_ev(KEY_CONFIRM, 1'b1, t_acc + 64);
        expect_ev(KEY_CONFIRM, 1'b1, t_acc + 84);
        expect_ev(KEY_CONFIRM, 1'b1, t_acc + 104);
        expect_ev(KEY_CONFIRM, 1'b1, t_acc + 124);
        expect_ev(KEY_CONFIRM, 1'b1, t_acc + 144);
`endif
        wait_cyc(LAT + 5);
        check("rst_hold_level", 32'(key_level), 32'h01);
        // Level stays high for 150 cycles after acceptance.
        wait_cyc(t_acc + 132 - cyc);
        key_raw[KEY_CONFIRM] = 1'b0;
        expect_ev(KEY_CONFIRM, 1'b0, cyc + LAT);
        wait_cyc(30);
        check("final_level", 32'(key_level), 32'h00);

        wait_cyc(5);
        while (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover key %0d: expected pulse at %0d never seen", sb[0].key, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
